// File: rtl/rx_chain_if.sv
// rx_chain_if: waveform input and recovered-stream outputs of the receive chain.
//   wav_recv   : 8-bit unsigned channel sample, midscale 128
//   bit_recv   : demodulated code bit, qualified by valid_recv
//   code_recv  : deinterleaved code bit, qualified by valid_deco
//   data_recv  : decoded data bit, qualified by data_valid
interface rx_chain_if;
    logic [7:0] wav_recv;
    logic       bit_recv;
    logic       valid_recv;
    logic       code_recv;
    logic       valid_deco;
    logic       data_recv;
    logic       data_valid;

    // master drives the waveform and observes the chain; slave is the receiver
    modport master (
        output wav_recv,
        input  bit_recv, valid_recv, code_recv, valid_deco, data_recv, data_valid
    );
    modport slave (
        input  wav_recv,
        output bit_recv, valid_recv, code_recv, valid_deco, data_recv, data_valid
    );
endinterface

// File: rtl/rx_chain.sv
// rx_chain: BPSK correlation demodulator -> ROWSxCOLS ping-pong block
// deinterleaver -> rate-1/2 K=3 (7,5) hard-decision register-exchange Viterbi.
//   clk   : one waveform sample per cycle
//   reset : synchronous, active-low
//   bus   : rx_chain_if.slave (wav_recv in; bit/code/data taps and strobes out)
module rx_chain #(
    parameter int unsigned SPB  = 16,
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned TB   = 12
) (
    input  logic      clk,
    input  logic      reset,
    rx_chain_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(SPB);
    localparam int unsigned ACC_W = (CNT_W + 9 > 13) ? CNT_W + 9 : 13;
    localparam int unsigned BLK   = ROWS * COLS;
    localparam int unsigned PTR_W = $clog2(BLK);
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned PC_W  = $clog2(TB + 1);
    localparam int unsigned PM_W  = 5;
    localparam int unsigned NS    = 4;

    // demodulator
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_sum_c;
    logic signed [8:0]       samp_c;
    logic                    bit_q, bit_d;
    logic                    vrecv_q, vrecv_d;
    // deinterleaver
    logic [1:0][BLK-1:0]     bank_q, bank_d;
    logic                    wsel_q, wsel_d;
    logic                    full_q, full_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ROW_W-1:0]        rd_r_q, rd_r_d;
    logic [COL_W-1:0]        rd_c_q, rd_c_d;
    logic [PTR_W-1:0]        rd_addr_c;
    logic                    code_q, code_d;
    logic                    vdeco_q, vdeco_d;
    // decoder
    logic                    half_q, half_d;
    logic                    g0_q, g0_d;
    logic [PC_W-1:0]         pcnt_q, pcnt_d;
    logic [NS-1:0][PM_W-1:0] pm_q, pm_d;
    logic [NS-1:0][TB-1:0]   surv_q, surv_d;
    logic                    data_q, data_d;
    logic                    dval_q, dval_d;
    logic [NS-1:0][PM_W:0]   cand0_c, cand1_c;
    logic [NS-1:0][PM_W-1:0] acs_pm_c;
    logic [NS-1:0][TB-1:0]   acs_surv_c;
    logic [NS-1:0]           acs_sel_c;
    logic                    all_hi_c;
    logic [1:0]              best_c;

    // Hamming distance between received pair and the branch into ns from
    // predecessor {ns[0], u2}; ns = {newest input, previous input}.
    function automatic logic [1:0] branch_metric(input logic [1:0] ns, input logic u2,
                                                 input logic r0, input logic r1);
        logic e0, e1;
        e0 = ns[1] ^ ns[0] ^ u2;
        e1 = ns[1] ^ u2;
        return {1'b0, r0 ^ e0} + {1'b0, r1 ^ e1};
    endfunction

    function automatic logic [PM_W-1:0] sat_metric(input logic [PM_W:0] m);
        return m[PM_W] ? '1 : m[PM_W-1:0];
    endfunction

    // add-compare-select; a tie keeps the lower-numbered predecessor
    always_comb begin
        cand0_c    = '0;
        cand1_c    = '0;
        acs_sel_c  = '0;
        acs_pm_c   = '0;
        acs_surv_c = '0;
        for (int i = 0; i < NS; i++) begin
            cand0_c[i] = {1'b0, pm_q[{i[0], 1'b0}]}
                       + {{(PM_W-1){1'b0}}, branch_metric(2'(i), 1'b0, g0_q, code_q)};
            cand1_c[i] = {1'b0, pm_q[{i[0], 1'b1}]}
                       + {{(PM_W-1){1'b0}}, branch_metric(2'(i), 1'b1, g0_q, code_q)};
            acs_sel_c[i] = cand1_c[i] < cand0_c[i];
            if (acs_sel_c[i]) begin
                acs_pm_c[i]   = sat_metric(cand1_c[i]);
                acs_surv_c[i] = {surv_q[{i[0], 1'b1}][TB-2:0], i[1]};
            end else begin
                acs_pm_c[i]   = sat_metric(cand0_c[i]);
                acs_surv_c[i] = {surv_q[{i[0], 1'b0}][TB-2:0], i[1]};
            end
        end
    end

    // normalisation flag and minimum-metric state (lowest index wins a tie)
    always_comb begin
        all_hi_c = 1'b1;
        best_c   = 2'd0;
        for (int i = 0; i < NS; i++) begin
            all_hi_c = all_hi_c & acs_pm_c[i][PM_W-1];
            if (pm_q[i] < pm_q[best_c]) best_c = 2'(i);
        end
    end

    // next-state logic for all three stages
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        acc_d    = acc_q;
        bit_d    = bit_q;
        vrecv_d  = 1'b0;
        bank_d   = bank_q;
        wsel_d   = wsel_q;
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_r_d   = rd_r_q;
        rd_c_d   = rd_c_q;
        code_d   = code_q;
        vdeco_d  = 1'b0;
        half_d   = half_q;
        g0_d     = g0_q;
        pcnt_d   = pcnt_q;
        pm_d     = pm_q;
        surv_d   = surv_q;
        data_d   = data_q;
        dval_d   = 1'b0;

        // correlate against +1 for the first half-symbol, -1 for the second
        samp_c = $signed({1'b0, bus.wav_recv}) - 9'sd128;
        if (cnt_q < CNT_W'(SPB / 2))
            acc_sum_c = acc_q + $signed({{(ACC_W-9){samp_c[8]}}, samp_c});
        else
            acc_sum_c = acc_q - $signed({{(ACC_W-9){samp_c[8]}}, samp_c});
        acc_d = acc_sum_c;
        if (cnt_q == CNT_W'(SPB - 1)) begin
            cnt_d   = '0;
            bit_d   = !acc_sum_c[ACC_W-1] && (acc_sum_c != '0);
            vrecv_d = 1'b1;
            acc_d   = '0;
        end

        // write row-major into one bank while reading the other column-major
        rd_addr_c = PTR_W'(rd_r_q) * PTR_W'(COLS) + PTR_W'(rd_c_q);
        if (vrecv_q) begin
            bank_d[wsel_q][wr_ptr_q] = bit_q;
            if (full_q) begin
                code_d  = bank_q[~wsel_q][rd_addr_c];
                vdeco_d = 1'b1;
                if (rd_r_q == ROW_W'(ROWS - 1)) begin
                    rd_r_d = '0;
                    rd_c_d = (rd_c_q == COL_W'(COLS - 1)) ? '0 : rd_c_q + COL_W'(1);
                end else begin
                    rd_r_d = rd_r_q + ROW_W'(1);
                end
            end
            if (wr_ptr_q == PTR_W'(BLK - 1)) begin
                wr_ptr_d = '0;
                wsel_d   = ~wsel_q;
                full_d   = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end

        // pair up code bits; the survivor bit shifted out is the decision
        if (vdeco_q) begin
            if (!half_q) begin
                g0_d   = code_q;
                half_d = 1'b1;
            end else begin
                half_d = 1'b0;
                for (int i = 0; i < NS; i++)
                    pm_d[i] = all_hi_c ? acs_pm_c[i] - PM_W'(16) : acs_pm_c[i];
                surv_d = acs_surv_c;
                if (pcnt_q == PC_W'(TB)) begin
                    data_d = surv_q[best_c][TB-1];
                    dval_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            bit_q    <= 1'b0;
            vrecv_q  <= 1'b0;
            bank_q   <= '0;
            wsel_q   <= 1'b0;
            full_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_r_q   <= '0;
            rd_c_q   <= '0;
            code_q   <= 1'b0;
            vdeco_q  <= 1'b0;
            half_q   <= 1'b0;
            g0_q     <= 1'b0;
            pcnt_q   <= '0;
            pm_q     <= {PM_W'(15), PM_W'(15), PM_W'(15), PM_W'(0)};
            surv_q   <= '0;
            data_q   <= 1'b0;
            dval_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            vrecv_q  <= vrecv_d;
            bank_q   <= bank_d;
            wsel_q   <= wsel_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_r_q   <= rd_r_d;
            rd_c_q   <= rd_c_d;
            code_q   <= code_d;
            vdeco_q  <= vdeco_d;
            half_q   <= half_d;
            g0_q     <= g0_d;
            pcnt_q   <= pcnt_d;
            pm_q     <= pm_d;
            surv_q   <= surv_d;
            data_q   <= data_d;
            dval_q   <= dval_d;
        end
    end

    assign bus.bit_recv   = bit_q;
    assign bus.valid_recv = vrecv_q;
    assign bus.code_recv  = code_q;
    assign bus.valid_deco = vdeco_q;
    assign bus.data_recv  = data_q;
    assign bus.data_valid = dval_q;
endmodule

// File: tb/tb_rx_chain.sv
// tb_rx_chain: randomized self-checking bench for rx_chain. A transmit-side
// model (encoder, interleaver, BPSK modulator) builds the waveform; expected
// taps come from plain-arithmetic demod sums and block index maps.
module tb_rx_chain;
    localparam int SPB  = 16;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int TB   = 12;
    localparam int BLK  = ROWS * COLS;

    logic clk = 1'b0;
    logic reset;

    rx_chain_if bus_i ();

    rx_chain #(.SPB(SPB), .ROWS(ROWS), .COLS(COLS), .TB(TB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit bit_obs[$];
    bit code_obs[$];
    bit data_obs[$];
    int vr_cyc[$];
    bit data_tx[$];
    bit code_tx[$];
    bit tx_bits[$];

    // observe strobed outputs well after the active edge
    always @(posedge clk) begin
        #2;
        cyc++;
        if (bus_i.valid_recv) begin
            bit_obs.push_back(bus_i.bit_recv);
            vr_cyc.push_back(cyc);
        end
        if (bus_i.valid_deco) code_obs.push_back(bus_i.code_recv);
        if (bus_i.data_valid) data_obs.push_back(bus_i.data_recv);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_sample(input logic [7:0] w);
        bus_i.wav_recv = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        bus_i.wav_recv = 8'd128;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bit_obs.delete();
        code_obs.delete();
        data_obs.delete();
        vr_cyc.delete();
        reset = 1'b1;
    endtask

    task automatic send_symbol(input bit b, input int amp);
        int lvl;
        for (int k = 0; k < SPB; k++) begin
            lvl = (bit'(k < SPB / 2) == b) ? 128 + amp : 128 - amp;
            drive_sample(8'(lvl));
        end
    endtask

    // encoder state holds the two previous inputs; g0 = 111, g1 = 101
    function automatic void encode_data();
        bit s1, s2;
        s1 = 1'b0;
        s2 = 1'b0;
        code_tx.delete();
        foreach (data_tx[i]) begin
            code_tx.push_back(data_tx[i] ^ s1 ^ s2);
            code_tx.push_back(data_tx[i] ^ s2);
            s2 = s1;
            s1 = data_tx[i];
        end
    endfunction

    // transmit slot r*COLS+c carries code bit c*ROWS+r of the same block
    function automatic void interleave_code();
        tx_bits.delete();
        for (int b = 0; b < code_tx.size() / BLK; b++)
            for (int i = 0; i < BLK; i++)
                tx_bits.push_back(code_tx[b * BLK + (i % COLS) * ROWS + i / COLS]);
    endfunction

    task automatic test_reset();
        logic [5:0] outs;
        apply_reset();
        outs = {bus_i.bit_recv, bus_i.valid_recv, bus_i.code_recv,
                bus_i.valid_deco, bus_i.data_recv, bus_i.data_valid};
        n_checks++;
        if (outs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000", outs);
        end
    endtask

    task automatic test_idle();
        apply_reset();
        for (int i = 0; i < 4 * BLK * SPB + 2; i++) drive_sample(8'd128);
        n_checks++;
        if (bit_obs.size() != 4 * BLK) begin
            n_fail++;
            $display("FAIL idle_bit_count: got %0d expected %0d", bit_obs.size(), 4 * BLK);
        end
        foreach (bit_obs[i]) begin
            n_checks++;
            if (bit_obs[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_bit[%0d]: got %b expected 0", i, bit_obs[i]);
            end
        end
        for (int i = 1; i < vr_cyc.size(); i++) begin
            n_checks++;
            if (vr_cyc[i] - vr_cyc[i-1] != SPB) begin
                n_fail++;
                $display("FAIL idle_strobe_gap[%0d]: got %0d expected %0d",
                         i, vr_cyc[i] - vr_cyc[i-1], SPB);
            end
        end
        n_checks++;
        if (data_obs.size() != 3 * BLK / 2 - TB) begin
            n_fail++;
            $display("FAIL idle_data_count: got %0d expected %0d", data_obs.size(), 3 * BLK / 2 - TB);
        end
        foreach (data_obs[i]) begin
            n_checks++;
            if (data_obs[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_data[%0d]: got %b expected 0", i, data_obs[i]);
            end
        end
    endtask

    task automatic test_carrier();
        int amp;
        bit pol;
        for (int cfg = 0; cfg < 4; cfg++) begin
            amp = (cfg < 2) ? 64 : 1;
            pol = (cfg % 2 == 0);
            apply_reset();
            for (int s = 0; s < 5; s++) send_symbol(pol, amp);
            n_checks++;
            if (bit_obs.size() != 5) begin
                n_fail++;
                $display("FAIL carrier_count amp=%0d pol=%0d: got %0d expected 5", amp, pol, bit_obs.size());
            end
            foreach (bit_obs[i]) begin
                n_checks++;
                if (bit_obs[i] !== pol) begin
                    n_fail++;
                    $display("FAIL carrier_bit amp=%0d [%0d]: got %b expected %b", amp, i, bit_obs[i], pol);
                end
            end
        end
    endtask

    task automatic test_demod_random();
        logic [7:0] w [SPB];
        int acc;
        bit exp_q[$];
        apply_reset();
        for (int s = 0; s < 10; s++) begin
            acc = 0;
            for (int k = 0; k < SPB; k++) begin
                // symbol 0 mirrors its halves to force a zero correlation
                if (s == 0 && k >= SPB / 2) w[k] = w[k - SPB / 2];
                else w[k] = 8'($urandom_range(0, 255));
                acc += (k < SPB / 2) ? (int'(w[k]) - 128) : (128 - int'(w[k]));
            end
            exp_q.push_back(acc > 0);
            for (int k = 0; k < SPB; k++) drive_sample(w[k]);
        end
        n_checks++;
        if (bit_obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL demod_rand_count: got %0d expected %0d", bit_obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < bit_obs.size(); i++) begin
            n_checks++;
            if (bit_obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL demod_rand[%0d]: got %b expected %b", i, bit_obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic run_deint(input string name, input int nblk);
        int idx;
        bit e;
        foreach (tx_bits[i]) send_symbol(tx_bits[i], 64);
        drive_sample(8'd128);
        n_checks++;
        if (code_obs.size() != (nblk - 1) * BLK) begin
            n_fail++;
            $display("FAIL %s_count: got %0d expected %0d", name, code_obs.size(), (nblk - 1) * BLK);
        end
        for (int b = 0; b < nblk - 1; b++)
            for (int k = 0; k < BLK; k++) begin
                idx = b * BLK + k;
                e   = tx_bits[b * BLK + (k % ROWS) * COLS + k / ROWS];
                if (idx < code_obs.size()) begin
                    n_checks++;
                    if (code_obs[idx] !== e) begin
                        n_fail++;
                        $display("FAIL %s[%0d]: got %b expected %b", name, idx, code_obs[idx], e);
                    end
                end
            end
    endtask

    task automatic test_deint_order();
        apply_reset();
        tx_bits.delete();
        for (int i = 0; i < 4 * BLK; i++)
            tx_bits.push_back(i == 0 || i == 2 * BLK + 1);
        run_deint("deint_fixed", 4);
        apply_reset();
        tx_bits.delete();
        for (int i = 0; i < 3 * BLK; i++) tx_bits.push_back(bit'($urandom_range(0, 1)));
        run_deint("deint_rand", 3);
    endtask

    task automatic check_decode(input string name, input int nblk, input int n_sent);
        n_checks++;
        if (bit_obs.size() != n_sent) begin
            n_fail++;
            $display("FAIL %s_bits: got %0d expected %0d", name, bit_obs.size(), n_sent);
        end
        n_checks++;
        if (code_obs.size() != nblk * BLK) begin
            n_fail++;
            $display("FAIL %s_code_count: got %0d expected %0d", name, code_obs.size(), nblk * BLK);
        end
        for (int i = 0; i < code_obs.size() && i < code_tx.size(); i++) begin
            n_checks++;
            if (code_obs[i] !== code_tx[i]) begin
                n_fail++;
                $display("FAIL %s_code[%0d]: got %b expected %b", name, i, code_obs[i], code_tx[i]);
            end
        end
        n_checks++;
        if (data_obs.size() != nblk * BLK / 2 - TB) begin
            n_fail++;
            $display("FAIL %s_data_count: got %0d expected %0d", name, data_obs.size(), nblk * BLK / 2 - TB);
        end
        for (int i = 0; i < data_obs.size() && i < data_tx.size(); i++) begin
            n_checks++;
            if (data_obs[i] !== data_tx[i]) begin
                n_fail++;
                $display("FAIL %s_data[%0d]: got %b expected %b", name, i, data_obs[i], data_tx[i]);
            end
        end
    endtask

    task automatic test_decode(input string name, input int nblk, input bit flips);
        int pos;
        apply_reset();
        data_tx.delete();
        for (int i = 0; i < nblk * BLK / 2; i++)
            data_tx.push_back(i < 4 ? bit'(i == 0 || i == 3) : bit'($urandom_range(0, 1)));
        encode_data();
        if (flips)
            for (int g = 0; g < code_tx.size() / 20; g++) begin
                pos = g * 20 + $urandom_range(0, 19);
                code_tx[pos] = ~code_tx[pos];
            end
        interleave_code();
        for (int i = 0; i < BLK; i++) tx_bits.push_back(1'b0);
        foreach (tx_bits[i]) send_symbol(tx_bits[i], 64);
        drive_sample(8'd128);
        drive_sample(8'd128);
        check_decode(name, nblk, tx_bits.size());
    endtask

    task automatic test_mid_reset();
        logic [5:0] outs;
        int lvl;
        apply_reset();
        for (int s = 0; s < BLK + 5; s++) send_symbol(bit'($urandom_range(0, 1)), 64);
        for (int k = 0; k < 7; k++) drive_sample(8'($urandom_range(0, 255)));
        reset = 1'b0;
        drive_sample(8'($urandom_range(0, 255)));
        drive_sample(8'($urandom_range(0, 255)));
        outs = {bus_i.bit_recv, bus_i.valid_recv, bus_i.code_recv,
                bus_i.valid_deco, bus_i.data_recv, bus_i.data_valid};
        n_checks++;
        if (outs !== 6'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b expected 000000", outs);
        end
        bit_obs.delete();
        code_obs.delete();
        data_obs.delete();
        reset = 1'b1;

        data_tx.delete();
        for (int i = 0; i < BLK; i++) data_tx.push_back(bit'($urandom_range(0, 1)));
        encode_data();
        interleave_code();
        for (int i = 0; i < BLK; i++) tx_bits.push_back(1'b0);
        // first symbol sample by sample: the strobe must follow sample SPB-1
        for (int k = 0; k < SPB; k++) begin
            lvl = (bit'(k < SPB / 2) == tx_bits[0]) ? 192 : 64;
            drive_sample(8'(lvl));
            n_checks++;
            if (bus_i.valid_recv !== bit'(k == SPB - 1)) begin
                n_fail++;
                $display("FAIL midrst_strobe[%0d]: got %b expected %b", k, bus_i.valid_recv, k == SPB - 1);
            end
        end
        for (int i = 1; i < tx_bits.size(); i++) send_symbol(tx_bits[i], 64);
        drive_sample(8'd128);
        drive_sample(8'd128);
        for (int i = 0; i < bit_obs.size() && i < tx_bits.size(); i++) begin
            n_checks++;
            if (bit_obs[i] !== tx_bits[i]) begin
                n_fail++;
                $display("FAIL midrst_bit[%0d]: got %b expected %b", i, bit_obs[i], tx_bits[i]);
            end
        end
        check_decode("midrst", 2, tx_bits.size());
    endtask

    initial begin
        reset          = 1'b0;
        bus_i.wav_recv = 8'd128;
        test_reset();
        test_idle();
        test_carrier();
        test_demod_random();
        test_deint_order();
        test_decode("dec_clean", 3, 1'b0);
        test_decode("dec_err", 5, 1'b1);
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_chain.md
Name: rx_chain

Overview:
- Receive half of the link: takes the noisy 8-bit waveform from the channel and returns the recovered data bits.
- Three stages in a pipeline:
  - BPSK correlation demodulator.
  - 4x4 block deinterleaver.
  - Rate-1/2, K=3 (generators 7,5 octal) hard-decision Viterbi decoder.
- Mirrors the transmit chain of encoder, interleaver and modulator.

Parameters:
- SPB, 16: waveform samples per code bit (even, at least 4).
- ROWS, 4: interleaver block rows.
- COLS, 4: interleaver block columns. ROWS*COLS must be even.
- TB, 12: Viterbi survivor (register-exchange) depth, in decoded bits.

Ports:
- clk  in  1  single clock; one waveform sample per cycle.
- reset  in  1  synchronous, active-low; 0 = reset.
- wav_recv  in  8  unsigned waveform sample, midscale 128.
- bit_recv  out  1  demodulated code bit (observation tap).
- valid_recv  out  1  one-cycle strobe, bit_recv valid.
- code_recv  out  1  deinterleaved code bit (observation tap).
- valid_deco  out  1  one-cycle strobe, code_recv valid.
- data_recv  out  1  decoded data bit.
- data_valid  out  1  one-cycle strobe, data_recv valid.

Behaviour:
- Reset: every output, counter, accumulator, buffer and survivor register goes to 0.
  - Viterbi metrics go to state0=0, other states=15.
  - Reset wins over all other activity, including mid-block and mid-symbol.
- Demodulator:
  - Sample counter runs 0..SPB-1; it starts at 0 on the first cycle with reset=1.
  - Signed accumulator is at least 13 bits.
  - For counter < SPB/2: acc += (wav_recv-128). Otherwise: acc -= (wav_recv-128).
  - On counter = SPB-1, after including that sample: bit_recv = (acc > 0), a tie gives 0. Pulse valid_recv for 1 cycle, then clear acc.
  - Symbol timing is fixed; there is no carrier or timing recovery.
- Deinterleaver:
  - Two banks of ROWS*COLS bits (ping-pong).
  - Write: each valid_recv bit goes in row-major order (index r*COLS+c) into the write bank.
  - Bank swap: when the write bank fills, it becomes the read bank.
  - Read: one bit per subsequent valid_recv strobe, column-major order (c*ROWS+r), driven on code_recv with a valid_deco pulse in the cycle after the strobe.
  - No output for the first block, so the stage latency is ROWS*COLS code bits.
  - No flow control; rates are equal by construction, so no overflow is possible.
- Decoder:
  - Consumes code_recv bits in pairs: first bit = g0 (111), second = g1 (101).
  - Pairs are aligned to block start; ROWS*COLS is even, so a block always ends on a pair boundary.
  - Per pair:
    - Branch metric = Hamming distance (0..2).
    - Add-compare-select over 4 states, with state = last two inputs.
    - Ties choose the lower-numbered predecessor.
  - Path metrics are 5-bit. When all four are at least 16, subtract 16 from each.
  - Register-exchange survivors are TB bits wide.
  - Output timing:
    - After TB pairs have been processed, each new pair yields data_recv = the oldest survivor bit of the minimum-metric state (tie goes to the lowest state).
    - data_valid pulses for 1 cycle, 1 cycle after the second bit of the pair.
  - Decoded stream = transmitted stream delayed by TB bits.
- End-to-end:
  - A data bit leaves the chain after ROWS*COLS code bits of deinterleave delay plus TB decoded bits of decoder delay.
  - Each decoded bit occupies 2*SPB cycles.
- Arithmetic: the accumulator is sign-extended; no stage saturates except the normalised path metrics.

Test Plan:
- Constant wav_recv=128 after reset: valid_recv pulses every 16 cycles and bit_recv=0. After the deinterleaver and decoder fill, data_recv=0 on every data_valid.
- Clean carrier, +64 for 8 samples then -64 for 8, repeating: every bit_recv=1. Inverted carrier: every bit_recv=0. Repeat with ±1 amplitude to check the decision threshold.
- Deinterleaver order: demod bits for block 0 = 1000 0000 0000 0000 (bit index 0 = 1). Then feed block 1 = all zeros, and block 2 with index 1 = 1 and the rest 0. Required: the code_recv read out during block 1 has its 1 at position 0; the read-out during block 2 has its 1 at position 4.
- Decoder, clean input: data 1,0,0,1 encodes to code 11 10 11 11 (pre-interleaving). Required: data_recv = 1,0,0,1 after TB decoded bits of latency.
- Decoder with one flipped code bit per 10 pairs: decoded data still matches the sent data.
- Mid-stream reset: assert reset=0 for 2 cycles during block 1. Required: all outputs return to 0, and timing restarts at counter 0 with no stale bits emitted.
